// File: rtl/video_sync_h_pkg.sv
// Shared video timing package: horizontal constants, raster mode encoding and
// the per-mode horizontal configuration payload (also used by the vertical stage).
package video_sync_h_pkg;

  localparam int unsigned HCNT_W = 9;
  typedef logic [HCNT_W-1:0] hcnt_t;

  localparam logic [1:0] RASTER_PENT = 2'b00;
  localparam logic [1:0] RASTER_60HZ = 2'b01;
  localparam logic [1:0] RASTER_48K  = 2'b10;
  localparam logic [1:0] RASTER_128K = 2'b11;

  typedef enum logic [1:0] {
    MODE_PENT = RASTER_PENT,
    MODE_60HZ = RASTER_60HZ,
    MODE_48K  = RASTER_48K,
    MODE_128K = RASTER_128K
  } raster_mode_e;

  localparam hcnt_t HPERIOD_STD  = HCNT_W'(448);
  localparam hcnt_t HPERIOD_128K = HCNT_W'(456);

  localparam hcnt_t HBLNK_BEG = HCNT_W'(0);
  localparam hcnt_t HSYNC_BEG = HCNT_W'(10);
  localparam hcnt_t HSYNC_END = HCNT_W'(43);
  localparam hcnt_t HBLNK_END = HCNT_W'(88);

  localparam hcnt_t HPIX_BEG_STD = HCNT_W'(140);
  localparam hcnt_t HPIX_END_STD = HCNT_W'(396);
  localparam hcnt_t HPIX_BEG_48K = HCNT_W'(136);
  localparam hcnt_t HPIX_END_48K = HCNT_W'(392);

  localparam hcnt_t HINT_BEG_PENT = HCNT_W'(2);
  localparam hcnt_t HINT_BEG_60HZ = HCNT_W'(2);
  localparam hcnt_t HINT_BEG_48K  = HCNT_W'(8);
  localparam hcnt_t HINT_BEG_128K = HCNT_W'(12);

  typedef struct packed {
    hcnt_t hperiod;
    hcnt_t hpix_beg;
    hcnt_t hpix_end;
    hcnt_t hint_beg;
  } hmode_cfg_t;

endpackage

// File: rtl/video_hmode_sel.sv
// Maps the latched raster mode to its line period, pixel window and INT position.
module video_hmode_sel
  import video_sync_h_pkg::*;
(
  input  raster_mode_e i_mode,
  output hmode_cfg_t   o_cfg_c
);

  always_comb begin
    o_cfg_c.hperiod  = HPERIOD_STD;
    o_cfg_c.hpix_beg = HPIX_BEG_STD;
    o_cfg_c.hpix_end = HPIX_END_STD;
    o_cfg_c.hint_beg = HINT_BEG_PENT;
    case (i_mode)
      MODE_PENT: o_cfg_c.hint_beg = HINT_BEG_PENT;
      MODE_60HZ: o_cfg_c.hint_beg = HINT_BEG_60HZ;
      MODE_48K: begin
        o_cfg_c.hpix_beg = HPIX_BEG_48K;
        o_cfg_c.hpix_end = HPIX_END_48K;
        o_cfg_c.hint_beg = HINT_BEG_48K;
      end
      MODE_128K: begin
        o_cfg_c.hperiod  = HPERIOD_128K;
        o_cfg_c.hint_beg = HINT_BEG_128K;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/video_sync_h.sv
// Horizontal video sync generator: pixel counter, blank/sync/pixel levels and strobes.
// Optional macro HINT_ADJ_EN adds the hint_adj input that offsets the INT position.
module video_sync_h
  import video_sync_h_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic [1:0] modes_raster,
`ifdef HINT_ADJ_EN
  input  logic [2:0] hint_adj,
`endif
  output logic       hblank,
  output logic       hsync,
  output logic       hsync_start,
  output logic       line_start,
  output logic       hint_start,
  output logic       hpix
);

  hcnt_t        r_hcount;
  raster_mode_e r_mode;
  hmode_cfg_t   w_cfg;
  logic         w_wrap;
  hcnt_t        w_hcount_next;
  hcnt_t        w_hint_pos;

  video_hmode_sel u_hmode_sel (
    .i_mode  (r_mode),
    .o_cfg_c (w_cfg)
  );

  assign w_wrap        = (r_hcount == (w_cfg.hperiod - HCNT_W'(1)));
  assign w_hcount_next = w_wrap ? '0 : (r_hcount + HCNT_W'(1));

`ifdef HINT_ADJ_EN
  logic [2:0] r_hint_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hint_adj <= 3'd0;
    end else if (cend && w_wrap) begin
      r_hint_adj <= hint_adj;
    end
  end

  assign w_hint_pos = w_cfg.hint_beg + HCNT_W'(r_hint_adj);
`else
  assign w_hint_pos = w_cfg.hint_beg;
`endif

  // Mode is only taken at the line wrap so a mid-line change lands on the next line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= '0;
      r_mode   <= MODE_PENT;
    end else if (cend) begin
      r_hcount <= w_hcount_next;
      if (w_wrap) begin
        r_mode <= raster_mode_e'(modes_raster);
      end
    end
  end

  // Outputs are decoded from the upcoming count so they move together with hcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hblank      <= 1'b1;
      hsync       <= 1'b0;
      hpix        <= 1'b0;
      hsync_start <= 1'b0;
      line_start  <= 1'b0;
      hint_start  <= 1'b0;
    end else begin
      hsync_start <= 1'b0;
      line_start  <= 1'b0;
      hint_start  <= 1'b0;
      if (cend) begin
        if (w_hcount_next == HBLNK_BEG) begin
          hblank <= 1'b1;
        end else if (w_hcount_next == HBLNK_END) begin
          hblank <= 1'b0;
        end
        if (w_hcount_next == HSYNC_BEG) begin
          hsync <= 1'b1;
        end else if (w_hcount_next == HSYNC_END) begin
          hsync <= 1'b0;
        end
        if (w_hcount_next == w_cfg.hpix_beg) begin
          hpix <= 1'b1;
        end else if (w_hcount_next == w_cfg.hpix_end) begin
          hpix <= 1'b0;
        end
        hsync_start <= (w_hcount_next == HSYNC_BEG);
        line_start  <= (w_hcount_next == HSYNC_END);
        hint_start  <= (w_hcount_next == w_hint_pos);
      end
    end
  end

endmodule

// File: tb/tb_video_sync_h.sv
// Scoreboard bench for video_sync_h: expected output edges/strobes are queued with
// their cend index and checked by a monitor as the DUT produces them.
module tb_video_sync_h;

  localparam int EV_HINT      = 0;
  localparam int EV_HS_START  = 1;
  localparam int EV_LN_START  = 2;
  localparam int EV_HSYNC_R   = 3;
  localparam int EV_HSYNC_F   = 4;
  localparam int EV_HBLANK_R  = 5;
  localparam int EV_HBLANK_F  = 6;
  localparam int EV_HPIX_R    = 7;
  localparam int EV_HPIX_F    = 8;

`ifdef HINT_ADJ_EN
  localparam int ADJ_TEST = 5;
`else
  localparam int ADJ_TEST = 0;
`endif

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       cend;
  logic [1:0] modes_raster;
  logic       hblank;
  logic       hsync;
  logic       hsync_start;
  logic       line_start;
  logic       hint_start;
  logic       hpix;
`ifdef HINT_ADJ_EN
  logic [2:0] hint_adj_drv;
`endif

  ev_t exp_q[$];
  int  total;
  int  bad;
  int  n_cend;
  int  cyc;
  int  hs_prev;
  int  hs_last;
  int  n_strobes;
  logic p_hblank, p_hsync, p_hpix;

  video_sync_h dut (
    .clk          (clk),
    .rst          (rst),
    .cend         (cend),
    .modes_raster (modes_raster),
`ifdef HINT_ADJ_EN
    .hint_adj     (hint_adj_drv),
`endif
    .hblank       (hblank),
    .hsync        (hsync),
    .hsync_start  (hsync_start),
    .line_start   (line_start),
    .hint_start   (hint_start),
    .hpix         (hpix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side count of cends since reset release; used as the event timestamp.
  always @(posedge clk or posedge rst) begin
    if (rst) n_cend <= 0;
    else if (cend) n_cend <= n_cend + 1;
  end

  task automatic set_adj(input int v);
`ifdef HINT_ADJ_EN
    hint_adj_drv = 3'(v);
`else
    if (v != 0) $display("note: hint_adj request %0d ignored in this build", v);
`endif
  endtask

  function automatic void push_ev(input int kind, input int at);
    int i;
    ev_t e;
    e.kind = kind;
    e.at   = at;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].at < at || (exp_q[i].at == at && exp_q[i].kind <= kind))) i++;
    exp_q.insert(i, e);
  endfunction

  // Queue one full line's events (hand-derived per mode); returns the line period.
  function automatic int push_line(input int base, input int mode, input int adj);
    int per, pb, pe, hb;
    per = 448; pb = 140; pe = 396; hb = 2;
    if (mode == 2) begin pb = 136; pe = 392; hb = 8; end
    if (mode == 3) begin per = 456; hb = 12; end
    push_ev(EV_HINT,     base + hb + adj);
    push_ev(EV_HSYNC_R,  base + 10);
    push_ev(EV_HS_START, base + 10);
    push_ev(EV_HSYNC_F,  base + 43);
    push_ev(EV_LN_START, base + 43);
    push_ev(EV_HBLANK_F, base + 88);
    push_ev(EV_HPIX_R,   base + pb);
    push_ev(EV_HPIX_F,   base + pe);
    push_ev(EV_HBLANK_R, base + per);
    return per;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_spurious: got kind=%0d at=%0d, want no event", kind, n_cend);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != n_cend) begin
        bad++;
        $display("FAIL sb_event: got kind=%0d at=%0d, want kind=%0d at=%0d",
                 kind, n_cend, e.kind, e.at);
      end
    end
  endtask

  task automatic mon_step();
    if (!rst) begin
      if (hint_start) sb_pop(EV_HINT);
      if (hsync_start) begin
        sb_pop(EV_HS_START);
        hs_prev = hs_last;
        hs_last = cyc;
      end
      if (line_start) sb_pop(EV_LN_START);
      if (hsync && !p_hsync) sb_pop(EV_HSYNC_R);
      if (!hsync && p_hsync) sb_pop(EV_HSYNC_F);
      if (hblank && !p_hblank) sb_pop(EV_HBLANK_R);
      if (!hblank && p_hblank) sb_pop(EV_HBLANK_F);
      if (hpix && !p_hpix) sb_pop(EV_HPIX_R);
      if (!hpix && p_hpix) sb_pop(EV_HPIX_F);
      n_strobes = n_strobes + int'(hint_start) + int'(hsync_start) + int'(line_start);
    end
    p_hblank = hblank;
    p_hsync  = hsync;
    p_hpix   = hpix;
  endtask

  task automatic run_cends(input int n);
    repeat (n) begin
      @(posedge clk); #1 cend = 1'b1;
      @(posedge clk); #1 cend = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_levels(input string tag);
    check({tag, "_hblank"},      int'(hblank),      1);
    check({tag, "_hsync"},       int'(hsync),       0);
    check({tag, "_hpix"},        int'(hpix),        0);
    check({tag, "_hsync_start"}, int'(hsync_start), 0);
    check({tag, "_line_start"},  int'(line_start),  0);
    check({tag, "_hint_start"},  int'(hint_start),  0);
  endtask

  initial begin
    int base;
    int snap;
    total = 0; bad = 0; n_strobes = 0; hs_prev = 0; hs_last = 0;
    p_hblank = 1'b1; p_hsync = 1'b0; p_hpix = 1'b0;
    rst = 1'b1; cend = 1'b0; modes_raster = 2'b00;
    set_adj(0);
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 check_reset_levels("rst_hold");
    rst = 1'b0;

    // Mode 00, three lines from reset.
    base = 0;
    base += push_line(base, 0, 0);
    base += push_line(base, 0, 0);
    base += push_line(base, 0, 0);
    run_cends(3 * 448);
    check("q_drain_m00", exp_q.size(), 0);
    check("hs_period_m00_clk", hs_last - hs_prev, 1792);

    // Mode 11 requested at line start: this line stays 00, next two are 456.
    modes_raster = 2'b11;
    base += push_line(base, 0, 0);
    base += push_line(base, 3, 0);
    base += push_line(base, 3, 0);
    run_cends(448 + 456 + 456);
    check("q_drain_m11", exp_q.size(), 0);
    check("hs_period_m11_clk", hs_last - hs_prev, 1824);

    // 00 line switched to 10 at hcount 200.
    modes_raster = 2'b00;
    base += push_line(base, 3, 0);
    base += push_line(base, 0, 0);
    base += push_line(base, 2, 0);
    run_cends(456 + 200);
    modes_raster = 2'b10;
    run_cends(248 + 448);
    check("q_drain_switch", exp_q.size(), 0);

    // cend stalled for 100 clk at hcount 9.
    modes_raster = 2'b00;
    base += push_line(base, 2, 0);
    run_cends(9);
    snap = n_strobes;
    repeat (100) @(posedge clk);
    #1;
    check("stall_no_strobe", n_strobes - snap, 0);
    check("stall_hsync_low", int'(hsync), 0);
    run_cends(1);
    check("stall_resume_hs", n_strobes - snap, 1);
    run_cends(438);
    check("q_drain_stall", exp_q.size(), 0);

    // Reset at hcount 300 of a mode-00 line for 3 clk.
    base += push_line(base, 0, 0);
    run_cends(300);
    check("pre_rst_hpix", int'(hpix), 1);
    check("pre_rst_hblank", int'(hblank), 0);
    rst = 1'b1;
    #1 check_reset_levels("rst_mid");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Post-reset lines; INT offset requested on the middle one.
    base = 0;
    set_adj(ADJ_TEST);
    base += push_line(base, 0, 0);
    run_cends(448);
    set_adj(0);
    base += push_line(base, 0, ADJ_TEST);
    base += push_line(base, 0, 0);
    run_cends(2 * 448);
    check("q_drain_post_rst", exp_q.size(), 0);
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
